load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side initiator for the unified word memory: accepts one RISC-V load or store at a time from the execute/memory pipeline stage and drives the memory's `rw`/`ain`/`din`/`dout` data port. Converts byte addresses to word indices, extracts and sign- or zero-extends sub-word loads, and implements SB/SH as read-modify-write, because the memory has no byte enables. Sits between the core's MEM stage and the data port of the memory block; the instruction port is untouched.

## Interface
- `MEM_WORDS`, 1024: memory depth in 32-bit words; legal byte addresses are 0 .. 4*MEM_WORDS-1.
- `IDX_BITS`, 10: log2(MEM_WORDS).

- `clock` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; the request is accepted on an edge where `req_valid && req_ready`.
- `req_store` in 1: 1 means store, 0 means load.
- `req_funct3` in 3: RISC-V funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; low byte/half is used for SB/SH.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result, already extended; 0 for stores and faults.
- `resp_fault` out 1: valid with `resp_valid`; signals misaligned, out-of-range, or illegal funct3.
- `mem_rw` out 1: 1 means write; to memory `rw`.
- `mem_ain` out 32: word index, zero-extended `req_addr[IDX_BITS+1:2]`.
- `mem_din` out 32: write data.
- `mem_dout` in 32: memory read data. It is registered in the memory: valid the cycle after a read edge, and held while `mem_rw`=1.

## Operation
- FSM states: IDLE, RD, LD, MRG, WR. `req_ready` = (state==IDLE).
- Accept with fault: no memory access. `resp_valid`=1 and `resp_fault`=1 are registered at the accept edge, and the FSM stays in IDLE. Fault conditions:
  - misaligned: H with addr[0]=1, or W with addr[1:0]!=0;
  - `req_addr` >= 4*MEM_WORDS;
  - illegal funct3.
- Load path: IDLE→RD→LD→IDLE.
  - RD drives `mem_rw`=0 and `mem_ain`=index.
  - In LD, the unit selects a byte/half lane by addr[1:0], extends it (LB/LH sign-extend; LBU/LHU zero-extend), and registers `resp_rdata` with `resp_valid`.
- SW path: IDLE→WR→IDLE. WR drives `mem_rw`=1 and `mem_din`=`req_wdata`. The response is registered on leaving WR.
- SB/SH path: IDLE→RD→MRG→WR→IDLE.
  - MRG registers `mem_din` = `mem_dout` with the addressed byte lane (addr[1:0]) or half lane (addr[1]) replaced by `req_wdata[7:0]`/`[15:0]`.
  - All other bytes are preserved.
- Request fields are latched at accept; later changes on `req_*` are ignored until the next acceptance.
- `mem_rw`=1 only in WR. `mem_ain`/`mem_din` hold their last value when IDLE.

## Timing
- Cycle numbering: cycle 1 is the first cycle after the accept edge.
- `resp_valid` high in:
  - fault: cycle 1;
  - SW: cycle 2;
  - loads: cycle 3;
  - SB/SH: cycle 4.
- `req_ready` returns high in the same cycle as `resp_valid`, so back-to-back requests lose no cycles.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_fault`=0, `resp_rdata`=0, `mem_rw`=0, `mem_ain`=0, `mem_din`=0.
- Reset mid-operation: state goes to IDLE at the reset edge. No write is issued after that edge, and no response is emitted for the aborted request.
- `resp_valid` is never high for two consecutive cycles from the same request.

## Structure
- Shared package `rv_pkg`: funct3 load/store constants, FSM state encoding, `MEM_WORDS` default.
- Sub-module `lsu_align` (combinational): load-extract/extend and store-merge from (funct3, addr[1:0], word, wdata).
- The top holds the FSM, request latch, and response registers.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 → memory word 4 written in cycle 1 (resp cycle 2); LW `resp_rdata`=0xDEADBEEF in cycle 3.
- With word 4 = 0x11223344: SB 0xAA @0x11 → word 4 = 0x1122AA44. SH 0xBEEF @0x12 → word 4 = 0xBEEFAA44, response in cycle 4.
- With word 4 = 0x8070F0FF: LB @0x10=0xFFFFFFFF, LBU @0x10=0x000000FF, LH @0x12=0xFFFF8070, LHU @0x12=0x00008070.
- Faults, each giving `resp_fault`=1 in cycle 1 with no `mem_rw` pulse: LW @0x13; SH @0x11; LB @0x1000; funct3=3 load.
- Reset asserted in MRG of SB @0x20 → word 8 unchanged, no `resp_valid`, `req_ready`=1 the cycle after reset.
- Back-to-back SW, LW, LBU with `req_valid` held → each accepted in the same cycle its predecessor's `resp_valid` is high, responses in order.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared definitions for the data-side load/store unit.
// Holds the RISC-V load/store funct3 encodings, the LSU FSM state type,
// the default memory depth, and small helpers that classify a request
// (legal funct3 for its direction, alignment for its access size).
package rv_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        LD,
        MRG,
        WR
    } lsu_state_t;

    // Stores only come in B/H/W flavours; the unsigned encodings are load-only.
    function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
        if (store) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // funct3[1:0] gives the access size for both loads and stores.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'd1:    return lane[0];
            2'd2:    return lane != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports:
//   funct3     - latched RISC-V funct3 of the request
//   lane       - byte offset addr[1:0] within the word
//   word       - word read back from memory
//   wdata      - low half of the store data
//   load_data  - selected byte/half, sign- or zero-extended
//   store_data - read word with the addressed byte/half replaced
module lsu_align
    import rv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase
    end

    // The memory has no byte enables, so sub-word stores rewrite the whole
    // word with every untouched byte carried over from the read.
    always_comb begin
        store_data = word;
        case (funct3[1:0])
            2'd0: store_data[{lane, 3'b000} +: 8] = wdata[7:0];
            2'd1: begin
                if (lane[1]) begin
                    store_data[31:16] = wdata;
                end else begin
                    store_data[15:0] = wdata;
                end
            end
            default: store_data = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RISC-V load/store initiator for the
// data port of the unified word memory.
// Ports:
//   clock, reset                  - rising-edge clock, synchronous active-high reset
//   req_valid/req_ready           - request handshake (ready only when idle)
//   req_store, req_funct3,
//   req_addr, req_wdata           - request fields, latched at accept
//   resp_valid, resp_rdata,
//   resp_fault                    - one-cycle completion pulse with result
//   mem_rw, mem_ain, mem_din      - memory data port controls (registered)
//   mem_dout                      - registered memory read data
module load_store_unit
    import rv_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int IDX_BITS  = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_rw,
    output logic [31:0] mem_ain,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    lsu_state_t  state;
    lsu_state_t  state_n;

    logic        store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        latch_en;
    logic        rw_n;
    logic [31:0] ain_n;
    logic [31:0] din_n;
    logic        rv_n;
    logic        rf_n;
    logic [31:0] rdata_n;

    logic        req_fault;
    logic [31:0] req_index;
    logic [31:0] load_data;
    logic [31:0] store_data;

    assign req_ready = (state == IDLE);
    assign req_index = {{(32 - IDX_BITS){1'b0}}, req_addr[IDX_BITS+1:2]};

    // Comparing the word part of the address avoids overflow in 4*MEM_WORDS.
    assign req_fault = !funct3_legal(req_store, req_funct3) ||
                       misaligned(req_funct3, req_addr[1:0]) ||
                       (req_addr[31:2] >= 30'(MEM_WORDS));

    lsu_align u_align (
        .funct3     (funct3_q),
        .lane       (lane_q),
        .word       (mem_dout),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Every memory-port and response output is registered, so the next
    // values are chosen here one cycle ahead of the state they belong to.
    // A faulting request never leaves IDLE; SW goes straight to WR because
    // there is nothing to merge.
    always_comb begin
        state_n  = state;
        latch_en = 1'b0;
        rw_n     = 1'b0;
        ain_n    = mem_ain;
        din_n    = mem_din;
        rv_n     = 1'b0;
        rf_n     = 1'b0;
        rdata_n  = resp_rdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault) begin
                        rv_n    = 1'b1;
                        rf_n    = 1'b1;
                        rdata_n = 32'd0;
                    end else begin
                        latch_en = 1'b1;
                        ain_n    = req_index;
                        if (req_store && (req_funct3 == F3_W)) begin
                            state_n = WR;
                            rw_n    = 1'b1;
                            din_n   = req_wdata;
                        end else begin
                            state_n = RD;
                        end
                    end
                end
            end
            RD: begin
                state_n = store_q ? MRG : LD;
            end
            LD: begin
                state_n = IDLE;
                rv_n    = 1'b1;
                rdata_n = load_data;
            end
            MRG: begin
                state_n = WR;
                rw_n    = 1'b1;
                din_n   = store_data;
            end
            WR: begin
                state_n = IDLE;
                rv_n    = 1'b1;
                rdata_n = 32'd0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A reset mid-operation also clears mem_rw, which is what stops a
    // pending read-modify-write from reaching memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'd0;
            mem_rw     <= 1'b0;
            mem_ain    <= 32'd0;
            mem_din    <= 32'd0;
            store_q    <= 1'b0;
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            wdata_q    <= 16'd0;
        end else begin
            resp_valid <= rv_n;
            resp_fault <= rf_n;
            resp_rdata <= rdata_n;
            mem_rw     <= rw_n;
            mem_ain    <= ain_n;
            mem_din    <= din_n;
            if (latch_en) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                lane_q   <= req_addr[1:0];
                wdata_q  <= req_wdata[15:0];
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit.
// Provides a registered-read word memory on the data port, a byte-array
// reference model of the load/store rules, a table of directed vectors,
// hand-written reset and back-to-back sequences, and a random phase.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_rw;
    logic [31:0] mem_ain;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_checks = 0;
    int n_errors = 0;
    int write_count = 0;

    logic [31:0] mem [1024];
    logic [7:0]  ref_mem [4096];

    typedef struct {
        logic        store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fault;
        logic [31:0] rdata;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    logic        b2b_store [3] = '{1'b1, 1'b0, 1'b0};
    logic [2:0]  b2b_f3    [3] = '{3'd2, 3'd2, 3'd4};
    logic [31:0] b2b_addr  [3] = '{32'h30, 32'h30, 32'h31};
    logic [31:0] b2b_wdata [3] = '{32'hCAFE1280, 32'h0, 32'h0};
    int          b2b_cycle [3] = '{2, 5, 8};
    logic [31:0] b2b_rdata [3] = '{32'h0, 32'hCAFE1280, 32'h00000012};

    load_store_unit #(.MEM_WORDS(1024), .IDX_BITS(10)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_rw     (mem_rw),
        .mem_ain    (mem_ain),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clock = ~clock;

    // Word memory with registered read data that holds during writes.
    always @(posedge clock) begin
        if (mem_rw) begin
            mem[mem_ain[9:0]] <= mem_din;
        end else begin
            mem_dout <= mem[mem_ain[9:0]];
        end
    end

    always @(posedge clock) begin
        if (mem_rw) write_count <= write_count + 1;
    end

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Byte-addressed reference: sizes, alignment, range and extension are
    // computed from the ISA rules directly; stores update the byte array.
    task automatic model_access(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic fault,
                                output logic [31:0] rdata, output int lat);
        int     size;
        bit     legal;
        longint v;
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = store ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        fault = !legal || (addr % size != 0) || (addr >= 32'd4096);
        rdata = 32'd0;
        if (fault) begin
            lat = 1;
        end else if (store) begin
            for (int i = 0; i < size; i++) ref_mem[int'(addr) + i] = 8'(wdata >> (8 * i));
            lat = (size == 4) ? 2 : 4;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_mem[int'(addr) + i]) << (8 * i);
            if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                v -= longint'(1) << (8 * size);
            rdata = v[31:0];
            lat = 3;
        end
    endtask

    // Issues one request from a negedge and watches eight cycles after the
    // accept edge; request fields are scrambled once accepted.
    task automatic apply_stimulus(input logic store, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, output int lat, output logic fault,
                                  output logic [31:0] rdata, output int pulses, output int writes,
                                  output logic ready_c1, output logic ready_resp);
        int w0;
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            check_output("ready_wait", 32'(req_ready), 32'd1);
        end
        req_valid  = 1'b1;
        req_store  = store;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        w0 = write_count;
        @(negedge clock);
        req_valid  = 1'b0;
        req_store  = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        ready_c1   = req_ready;
        lat = 0; pulses = 0; fault = 1'b0; rdata = 32'd0; ready_resp = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            if (n > 1) @(negedge clock);
            if (resp_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat        = n;
                    fault      = resp_fault;
                    rdata      = resp_rdata;
                    ready_resp = req_ready;
                end
            end
        end
        writes = write_count - w0;
    endtask

    task automatic do_and_check(input string tag, input logic store, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic exp_fault, input logic [31:0] exp_rdata, input int exp_lat);
        int lat, pulses, writes;
        logic fault, ready_c1, ready_resp;
        logic [31:0] rdata;
        apply_stimulus(store, f3, addr, wdata, lat, fault, rdata, pulses, writes, ready_c1, ready_resp);
        check_output({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_output({tag, " fault"}, 32'(fault), 32'(exp_fault));
        check_output({tag, " rdata"}, rdata, exp_rdata);
        check_output({tag, " pulses"}, 32'(pulses), 32'd1);
        check_output({tag, " writes"}, 32'(writes), (store && !exp_fault) ? 32'd1 : 32'd0);
        check_output({tag, " ready_at_resp"}, 32'(ready_resp), 32'd1);
        if (exp_lat > 1) check_output({tag, " ready_c1"}, 32'(ready_c1), 32'd0);
    endtask

    initial begin
        logic        m_fault;
        logic [31:0] m_rdata;
        int          m_lat;
        int          issued;
        int          got;
        int          w0;
        int          stray;

        foreach (ref_mem[i]) ref_mem[i] = 8'd0;

        vecs.push_back('{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3});
        vecs.push_back('{1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, 32'h0, 2});
        vecs.push_back('{1'b1, 3'd0, 32'h11, 32'h123456AA, 1'b0, 32'h0, 4});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h1122AA44, 3});
        vecs.push_back('{1'b1, 3'd1, 32'h12, 32'h7777BEEF, 1'b0, 32'h0, 4});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hBEEFAA44, 3});
        vecs.push_back('{1'b1, 3'd2, 32'h10, 32'h8070F0FF, 1'b0, 32'h0, 2});
        vecs.push_back('{1'b0, 3'd0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFFF, 3});
        vecs.push_back('{1'b0, 3'd4, 32'h10, 32'h0, 1'b0, 32'h000000FF, 3});
        vecs.push_back('{1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 32'hFFFF8070, 3});
        vecs.push_back('{1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 32'h00008070, 3});
        vecs.push_back('{1'b0, 3'd0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFF0, 3});
        vecs.push_back('{1'b0, 3'd4, 32'h13, 32'h0, 1'b0, 32'h00000080, 3});
        vecs.push_back('{1'b0, 3'd1, 32'h10, 32'h0, 1'b0, 32'hFFFFF0FF, 3});
        vecs.push_back('{1'b0, 3'd5, 32'h10, 32'h0, 1'b0, 32'h0000F0FF, 3});
        vecs.push_back('{1'b0, 3'd2, 32'h13, 32'h0, 1'b1, 32'h0, 1});
        vecs.push_back('{1'b1, 3'd1, 32'h11, 32'h0000FFFF, 1'b1, 32'h0, 1});
        vecs.push_back('{1'b0, 3'd0, 32'h1000, 32'h0, 1'b1, 32'h0, 1});
        vecs.push_back('{1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 32'h0, 1});
        vecs.push_back('{1'b1, 3'd4, 32'h10, 32'h12345678, 1'b1, 32'h0, 1});
        vecs.push_back('{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0, 1'b1, 32'h0, 1});
        vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h8070F0FF, 3});
        vecs.push_back('{1'b1, 3'd2, 32'hFFC, 32'hA5000000, 1'b0, 32'h0, 2});
        vecs.push_back('{1'b0, 3'd0, 32'hFFF, 32'h0, 1'b0, 32'hFFFFFFA5, 3});
        vecs.push_back('{1'b0, 3'd2, 32'hFFC, 32'h0, 1'b0, 32'hA5000000, 3});

        reset = 1'b1; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        @(negedge clock);
        @(negedge clock);
        check_output("reset req_ready", 32'(req_ready), 32'd1);
        check_output("reset resp_valid", 32'(resp_valid), 32'd0);
        check_output("reset resp_fault", 32'(resp_fault), 32'd0);
        check_output("reset resp_rdata", resp_rdata, 32'd0);
        check_output("reset mem_rw", 32'(mem_rw), 32'd0);
        check_output("reset mem_ain", mem_ain, 32'd0);
        check_output("reset mem_din", mem_din, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] directed vector table");
        foreach (vecs[i]) begin
            model_access(vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata, m_fault, m_rdata, m_lat);
            do_and_check($sformatf("vec%0d", i), vecs[i].store, vecs[i].f3, vecs[i].addr,
                         vecs[i].wdata, vecs[i].fault, vecs[i].rdata, vecs[i].lat);
        end
        check_output("word4 contents", mem[4], 32'h8070F0FF);

        $display("[TB] reset during read-modify-write");
        model_access(1'b1, 3'd2, 32'h20, 32'h55667788, m_fault, m_rdata, m_lat);
        do_and_check("pre_sw", 1'b1, 3'd2, 32'h20, 32'h55667788, 1'b0, 32'h0, 2);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd0;
        req_addr = 32'h20; req_wdata = 32'h000000EE;
        w0 = write_count;
        @(negedge clock);
        req_valid = 1'b0;
        check_output("abort c1 ready", 32'(req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_output("abort ready after reset", 32'(req_ready), 32'd1);
        check_output("abort mem_rw", 32'(mem_rw), 32'd0);
        check_output("abort mem_din", mem_din, 32'd0);
        stray = resp_valid ? 1 : 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (resp_valid) stray++;
        end
        check_output("abort resp pulses", 32'(stray), 32'd0);
        check_output("abort writes", 32'(write_count - w0), 32'd0);
        check_output("abort word8", mem[8], 32'h55667788);
        do_and_check("abort lw", 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'h55667788, 3);

        $display("[TB] back-to-back SW, LW, LBU");
        for (int k = 0; k < 3; k++)
            model_access(b2b_store[k], b2b_f3[k], b2b_addr[k], b2b_wdata[k], m_fault, m_rdata, m_lat);
        req_valid = 1'b1; req_store = b2b_store[0]; req_funct3 = b2b_f3[0];
        req_addr = b2b_addr[0]; req_wdata = b2b_wdata[0];
        issued = 1; got = 0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clock);
            if (resp_valid) begin
                if (got < 3) begin
                    check_output($sformatf("b2b%0d cycle", got), 32'(cyc), 32'(b2b_cycle[got]));
                    check_output($sformatf("b2b%0d rdata", got), resp_rdata, b2b_rdata[got]);
                    check_output($sformatf("b2b%0d fault", got), 32'(resp_fault), 32'd0);
                    check_output($sformatf("b2b%0d ready", got), 32'(req_ready), 32'd1);
                end
                got++;
            end
            if (req_ready) begin
                if (issued < 3) begin
                    req_store = b2b_store[issued]; req_funct3 = b2b_f3[issued];
                    req_addr = b2b_addr[issued]; req_wdata = b2b_wdata[issued];
                    issued++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        check_output("b2b response count", 32'(got), 32'd3);

        $display("[TB] random phase");
        for (int w = 0; w < 16; w++) begin
            logic [31:0] wd;
            wd = $urandom;
            model_access(1'b1, 3'd2, 32'(w * 4), wd, m_fault, m_rdata, m_lat);
            do_and_check($sformatf("init%0d", w), 1'b1, 3'd2, 32'(w * 4), wd, m_fault, m_rdata, m_lat);
        end
        for (int i = 0; i < 200; i++) begin
            logic        st;
            logic [2:0]  f3;
            logic [31:0] ad;
            logic [31:0] wd;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            if ($urandom_range(0, 9) == 0) ad = 32'h1000 + 32'($urandom_range(0, 4095));
            else ad = 32'($urandom_range(0, 63));
            model_access(st, f3, ad, wd, m_fault, m_rdata, m_lat);
            do_and_check($sformatf("rnd%0d", i), st, f3, ad, wd, m_fault, m_rdata, m_lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
